osnt_sume_tx_pacer: RTL and testbench

- Packet-granular pacing controller between the 10G TX queue output and the MAC TX AXI-Stream.
- Gates the stream so each packet start is released only when enabled and allowed. Enforces a programmable inter-packet gap in clock cycles and an optional per-burst packet budget.
- Zero-latency pass-through of data; only the valid/ready handshake is gated.

---
 rtl/osnt_sume_tx_pacer_pkg.sv | 12 +
 rtl/osnt_sume_tx_pacer_if.sv | 11 +
 rtl/osnt_sume_tx_pacer_gap_timer.sv | 17 +
 rtl/osnt_sume_tx_pacer.sv | 86 ++++++++
 tb/tb_osnt_sume_tx_pacer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/osnt_sume_tx_pacer_pkg.sv
// osnt_sume_tx_pacer_pkg: shared states, widths and tkeep popcount for the TX pacer.
package osnt_sume_tx_pacer_pkg;
  localparam int AXIS_DW = 64;
  localparam int CFG_DW  = 32;
  localparam int CNT_DW  = 64;
  localparam int KEEP_W  = AXIS_DW / 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3} state_e;
  function automatic logic [CNT_DW-1:0] keep_popcount(input logic [KEEP_W-1:0] keep);
    keep_popcount = '0;
    for (int i = 0; i < KEEP_W; i++) keep_popcount += CNT_DW'(keep[i]);
  endfunction
endpackage

// File: rtl/osnt_sume_tx_pacer_if.sv
// osnt_sume_tx_pacer_if: AXI-Stream bundle with master/slave views.
interface osnt_sume_tx_pacer_if #(parameter int DW = 64);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/osnt_sume_tx_pacer_gap_timer.sv
// osnt_sume_tx_pacer_gap_timer: loadable down-counter, expires when it reads 1.
module osnt_sume_tx_pacer_gap_timer #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign value_o  = cnt_q;
  assign expire_o = cnt_q == W'(1);
endmodule

// File: rtl/osnt_sume_tx_pacer.sv
// osnt_sume_tx_pacer: packet-granular TX gate with inter-packet gap and burst budget.
// Optional OSNT_SUME_TX_PACER_BYTE_STATS_EN adds a tx_byte_count output.
module osnt_sume_tx_pacer
  import osnt_sume_tx_pacer_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = AXIS_DW,
  parameter int C_S_AXI_DATA_WIDTH = CFG_DW,
  parameter int CNT_WIDTH          = CNT_DW
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  osnt_sume_tx_pacer_if.slave           s_axis,
  osnt_sume_tx_pacer_if.master          m_axis,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] ipg_cycles,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] burst_pkts,
  output logic [CNT_WIDTH-1:0]          pkt_sent_count,
  output logic                          busy
`ifdef OSNT_SUME_TX_PACER_BYTE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]          tx_byte_count
`endif
);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] burst_q, burst_d, gap_val;
  logic exhausted, gate, hs, pkt_end, gap_load, gap_expire;
  assign exhausted = (burst_pkts != '0) && (burst_q >= burst_pkts);
  // Reset is folded into the gate so nothing is offered while it is asserted
  assign gate = axis_resetn & ((state_q == SEND) | ((state_q == IDLE) & enable & ~exhausted));
  assign hs   = s_axis.tvalid & m_axis.tready & gate;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tvalid = s_axis.tvalid & gate;
  assign s_axis.tready = m_axis.tready & gate;
  always_comb begin
    state_d = state_q;
    pkt_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (exhausted) state_d = DONE;
        else if (hs & ~s_axis.tlast) state_d = SEND;
        else if (hs) pkt_end = 1'b1;
      end
      SEND: pkt_end = hs & s_axis.tlast;
      GAP:  state_d = (gap_expire || gap_val == '0) ? IDLE : GAP;
      DONE: state_d = (!enable || clear) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (pkt_end) state_d = (ipg_cycles != '0) ? GAP : IDLE;
    pkt_d   = clear ? '0 : pkt_q + CNT_WIDTH'(pkt_end);
    burst_d = (clear || (state_q == DONE && state_d == IDLE)) ? '0 : burst_q + C_S_AXI_DATA_WIDTH'(pkt_end);
  end
  assign gap_load = pkt_end & (ipg_cycles != '0);
  osnt_sume_tx_pacer_gap_timer #(.W(C_S_AXI_DATA_WIDTH)) u_gap (
    .clk       (axis_aclk),
    .rst_n     (axis_resetn),
    .load_i    (gap_load),
    .load_val_i(ipg_cycles),
    .value_o   (gap_val),
    .expire_o  (gap_expire)
  );
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      burst_q <= burst_d;
    end
  assign pkt_sent_count = pkt_q;
  assign busy = (state_q == SEND) | (state_q == GAP);
`ifdef OSNT_SUME_TX_PACER_BYTE_STATS_EN
  logic [CNT_WIDTH-1:0] byte_q;
  always_ff @(posedge axis_aclk or negedge axis_resetn)
    if (!axis_resetn) byte_q <= '0;
    else if (clear) byte_q <= '0;
    else if (hs) byte_q <= byte_q + CNT_WIDTH'(keep_popcount(s_axis.tkeep));
  assign tx_byte_count = byte_q;
`endif
endmodule

// File: tb/tb_osnt_sume_tx_pacer.sv
// tb_osnt_sume_tx_pacer: directed scenarios for the TX pacer with hand-computed expectations.
module tb_osnt_sume_tx_pacer;
  import osnt_sume_tx_pacer_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic enable, clear, busy;
  logic [31:0] ipg, burst;
  logic [63:0] pkt_cnt;
`ifdef OSNT_SUME_TX_PACER_BYTE_STATS_EN
  logic [63:0] bytes;
`endif
  always #5 clk = ~clk;
  osnt_sume_tx_pacer_if #(.DW(64)) s_if();
  osnt_sume_tx_pacer_if #(.DW(64)) m_if();
  osnt_sume_tx_pacer dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .enable        (enable),
    .clear         (clear),
    .ipg_cycles    (ipg),
    .burst_pkts    (burst),
    .pkt_sent_count(pkt_cnt),
    .busy          (busy)
`ifdef OSNT_SUME_TX_PACER_BYTE_STATS_EN
    ,
    .tx_byte_count (bytes)
`endif
  );
  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  beat_t src[$];
  beat_t outq[$];
  int out_cyc[$];
  bit bt[$];
  int idx, cyc, vec, err;
  bit en_v, clr_v, clr_on_last, tog;

  task automatic cycle();
    @(negedge clk);
    enable = en_v;
    if (idx < src.size()) begin
      s_if.tvalid = 1'b1; s_if.tdata = src[idx].d; s_if.tkeep = src[idx].k; s_if.tlast = src[idx].l;
    end else begin
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    end
    m_if.tready = tog ? cyc[0] : 1'b1;
    clear = clr_v | (clr_on_last & s_if.tvalid & s_if.tlast);
    #1;
    bt.push_back(busy);
    if (tog && s_if.tvalid) begin
      vec++;
      if (s_if.tready !== m_if.tready) begin
        err++; $display("FAIL ready_mirror cyc %0d: s_tready=%b m_tready=%b", cyc, s_if.tready, m_if.tready);
      end
    end
    if (m_if.tvalid && m_if.tready) begin
      outq.push_back('{m_if.tdata, m_if.tkeep, m_if.tlast});
      out_cyc.push_back(cyc);
    end
    if (s_if.tvalid && s_if.tready) idx++;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_empty(int max);
    int n = 0;
    while (idx < src.size() && n < max) begin cycle(); n++; end
    vec++;
    if (idx < src.size()) begin
      err++; $display("FAIL drain_timeout: consumed %0d of %0d beats", idx, src.size());
    end
  endtask

  task automatic add_pkt(int p, int n);
    for (int b = 0; b < n; b++) src.push_back('{{32'(p), 32'(b)}, 8'hFF, b == n - 1});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en_v = 0; clr_v = 0; clr_on_last = 0; tog = 0;
    enable = 0; clear = 0; ipg = 0; burst = 0;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0; s_if.tuser = 0;
    m_if.tready = 1'b1;
    src.delete(); outq.delete(); out_cyc.delete(); bt.delete();
    idx = 0; cyc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b1; s_if.tvalid = 1'b1; s_if.tlast = 1'b0; m_if.tready = 1'b1;
    #1;
    vec += 5;
    if (m_if.tvalid !== 1'b0) begin err++; $display("FAIL reset_m_tvalid: got %b want 0", m_if.tvalid); end
    if (s_if.tready !== 1'b0) begin err++; $display("FAIL reset_s_tready: got %b want 0", s_if.tready); end
    if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (pkt_cnt !== 64'd0) begin err++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    if (dut.state_q !== IDLE) begin err++; $display("FAIL reset_state: got %0d want 0", dut.state_q); end
  endtask

  task automatic test_back_to_back();
    do_reset(); en_v = 1;
    for (int p = 0; p < 3; p++) add_pkt(p, 4);
    run_until_empty(40); idle(3);
    vec += 3;
    if (outq.size() !== 12) begin err++; $display("FAIL b2b_beats: got %0d want 12", outq.size()); end
    else begin
      if (out_cyc[11] - out_cyc[0] !== 11) begin err++; $display("FAIL b2b_span: got %0d want 11", out_cyc[11] - out_cyc[0]); end
      for (int i = 0; i < 12; i++) begin
        vec++;
        if (outq[i].d !== {32'(i / 4), 32'(i % 4)} || outq[i].l !== (i % 4 == 3)) begin
          err++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", i, outq[i].d, outq[i].l, {32'(i / 4), 32'(i % 4)}, i % 4 == 3);
        end
      end
    end
    if (pkt_cnt !== 64'd3) begin err++; $display("FAIL b2b_pkt_cnt: got %0d want 3", pkt_cnt); end
  endtask

  task automatic test_ipg();
    int nb = 0;
    do_reset(); en_v = 1; ipg = 5;
    add_pkt(0, 2); add_pkt(1, 2);
    run_until_empty(40); idle(8);
    vec += 4;
    if (outq.size() !== 4) begin err++; $display("FAIL ipg_beats: got %0d want 4", outq.size()); end
    else begin
      if (out_cyc[2] - out_cyc[1] - 1 !== 5) begin err++; $display("FAIL ipg_gap: got %0d want 5", out_cyc[2] - out_cyc[1] - 1); end
      for (int c = out_cyc[0] + 1; c < out_cyc[2]; c++) nb += int'(bt[c]);
      if (nb !== 6) begin err++; $display("FAIL ipg_busy: got %0d busy cycles want 6", nb); end
    end
    if (pkt_cnt !== 64'd2 || busy !== 1'b0) begin err++; $display("FAIL ipg_end: got cnt %0d busy %b want 2/0", pkt_cnt, busy); end
  endtask

  task automatic test_burst();
    do_reset(); en_v = 1; burst = 2;
    for (int p = 0; p < 4; p++) add_pkt(p, 2);
    idle(20);
    vec += 5;
    if (outq.size() !== 4) begin err++; $display("FAIL burst_first_beats: got %0d want 4", outq.size()); end
    if (dut.state_q !== DONE) begin err++; $display("FAIL burst_state: got %0d want 3", dut.state_q); end
    if (s_if.tready !== 1'b0) begin err++; $display("FAIL burst_s_tready: got %b want 0", s_if.tready); end
    if (pkt_cnt !== 64'd2) begin err++; $display("FAIL burst_pkt_cnt1: got %0d want 2", pkt_cnt); end
    if (m_if.tvalid !== 1'b0) begin err++; $display("FAIL burst_m_tvalid: got %b want 0", m_if.tvalid); end
    en_v = 0; idle(2); en_v = 1;
    run_until_empty(40); idle(3);
    vec += 2;
    if (outq.size() !== 8 || outq[7].d !== {32'd3, 32'd1}) begin
      err++; $display("FAIL burst_rearm_beats: got %0d beats want 8 ending 0000000300000001", outq.size());
    end
    if (pkt_cnt !== 64'd4) begin err++; $display("FAIL burst_pkt_cnt2: got %0d want 4", pkt_cnt); end
  endtask

  task automatic test_enable_drop();
    int n = 0;
    do_reset(); en_v = 1;
    add_pkt(0, 6); add_pkt(1, 2);
    while (outq.size() < 2 && n < 20) begin cycle(); n++; end
    en_v = 0; idle(20);
    vec += 3;
    if (outq.size() !== 6) begin err++; $display("FAIL endrop_beats: got %0d want 6", outq.size()); end
    else if (outq[5].l !== 1'b1 || outq[5].d !== {32'd0, 32'd5}) begin err++; $display("FAIL endrop_last: got %h/%b want 0000000000000005/1", outq[5].d, outq[5].l); end
    if (m_if.tvalid !== 1'b0 || s_if.tready !== 1'b0) begin err++; $display("FAIL endrop_held: got tvalid %b tready %b want 0/0", m_if.tvalid, s_if.tready); end
    en_v = 1; run_until_empty(20);
    vec++;
    if (outq.size() !== 8 || outq[6].d !== {32'd1, 32'd0}) begin err++; $display("FAIL endrop_resume: got %0d beats want 8", outq.size()); end
  endtask

  task automatic test_tready_toggle();
    do_reset(); en_v = 1; tog = 1;
    add_pkt(7, 4);
    run_until_empty(40); tog = 0; idle(3);
    vec += 2;
    if (outq.size() !== 4) begin err++; $display("FAIL toggle_beats: got %0d want 4", outq.size()); end
    else for (int i = 0; i < 4; i++) begin
      vec++;
      if (outq[i].d !== {32'd7, 32'(i)} || outq[i].l !== (i == 3)) begin
        err++; $display("FAIL toggle_data[%0d]: got %h want %h", i, outq[i].d, {32'd7, 32'(i)});
      end
    end
    if (pkt_cnt !== 64'd1) begin err++; $display("FAIL toggle_pkt_cnt: got %0d want 1", pkt_cnt); end
  endtask

  task automatic test_clear_on_tlast();
    do_reset(); en_v = 1;
    add_pkt(0, 2);
    run_until_empty(20); idle(2);
    vec++;
    if (pkt_cnt !== 64'd1) begin err++; $display("FAIL clr_pre_cnt: got %0d want 1", pkt_cnt); end
    clr_on_last = 1; add_pkt(1, 2);
    run_until_empty(20); clr_on_last = 0; idle(2);
    vec += 2;
    if (pkt_cnt !== 64'd0) begin err++; $display("FAIL clr_tlast_cnt: got %0d want 0", pkt_cnt); end
    if (outq.size() !== 4) begin err++; $display("FAIL clr_beats: got %0d want 4", outq.size()); end
  endtask

`ifdef OSNT_SUME_TX_PACER_BYTE_STATS_EN
  task automatic test_byte_stats();
    do_reset(); en_v = 1;
    src.push_back('{64'h1, 8'hFF, 1'b0});
    src.push_back('{64'h2, 8'hFF, 1'b0});
    src.push_back('{64'h3, 8'h0F, 1'b1});
    run_until_empty(20); idle(2);
    vec++;
    if (bytes !== 64'd20) begin err++; $display("FAIL bytes_sum: got %0d want 20", bytes); end
    clr_v = 1; cycle(); clr_v = 0; idle(1);
    vec++;
    if (bytes !== 64'd0) begin err++; $display("FAIL bytes_clear: got %0d want 0", bytes); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec = 0; err = 0;
    test_reset();
    test_back_to_back();
    test_ipg();
    test_burst();
    test_enable_drop();
    test_tready_toggle();
    test_clear_on_tlast();
`ifdef OSNT_SUME_TX_PACER_BYTE_STATS_EN
    test_byte_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
